axis_data_unpackge: RTL and testbench
=====================================

Name: axis_data_unpackge

Overview:
- Host-to-card counterpart of the c2h packer. Receives 512-bit AXIS h2c beats from the DMA and strips the group framing.
- Reassembles DATA_WIDTH-bit records and presents them to core logic through a valid/ready port.
- Checks group sequence number and tlast framing, and resynchronises on errors.
- Sits between the XDMA h2c stream and core-side consumers, on the s_axis_h2c_aclk domain.

Parameters:
- DATA_WIDTH, 16000, width of one reassembled record in bits.
- AXIS_DATA_WIDTH, 512, AXIS tdata width (tkeep = AXIS_DATA_WIDTH/8 bits).
- NUM_PACKETS_PER_GROUP, 8, records per group (one tlast per group).

Ports:
- s_axis_h2c_aclk  in  1  sole clock.
- s_axis_h2c_areset  in  1  reset; synchronous to s_axis_h2c_aclk, active-high.
- s_axis_h2c_tdata  in  AXIS_DATA_WIDTH  beat payload.
- s_axis_h2c_tkeep  in  AXIS_DATA_WIDTH/8  ignored (all beats full width).
- s_axis_h2c_tlast  in  1  end of group.
- s_axis_h2c_tvalid  in  1  beat valid.
- s_axis_h2c_tready  out  1  beat accepted when tvalid&tready.
- data_out  out  DATA_WIDTH  reassembled record.
- data_out_valid  out  1  record available.
- data_out_ready  in  1  consumer accepts record.
- seq_num  out  8  sequence byte of the current group.
- seq_err  out  1  one-cycle pulse on sequence mismatch.
- frame_err  out  1  one-cycle pulse on tlast framing error.
- err_cnt  out  16  saturating count of seq_err + frame_err pulses.
- rx_state  out  3  one-hot FSM state, for debug.

Behaviour:
- Frame format, LSB-first:
  - Record 0 of a group spans B0 = ceil((DATA_WIDTH+8)/AXIS_DATA_WIDTH) beats. Beat 0 bits[7:0] = group sequence byte; bits[AW-1:8] = record bits[AW-9:0].
  - Records 1..N-1 span BN = ceil(DATA_WIDTH/AXIS_DATA_WIDTH) beats each.
  - Pad bits above the record end are ignored.
  - tlast is expected only on the final beat of record N-1.
- Counters:
  - beat_cnt (8b) counts beats within a record; rec_cnt counts records within a group.
  - Both wrap to 0 at record and group end respectively.
- FSM states: ASM=3'b001, FULL=3'b010, DROP=3'b100.
  - ASM: s_axis_h2c_tready=1. Each accepted beat is shifted into the assembly register. On the final beat of a record, go to FULL.
  - FULL: tready=0. The record moves to the output register when !data_out_valid or data_out_ready; then go to ASM.
  - DROP: tready=1. Beats are discarded. On an accepted beat with tlast=1, go to ASM with beat_cnt=rec_cnt=0.
- Output register:
  - data_out_valid is held until data_out_ready. data_out is stable while valid and not accepted.
  - Throughput: at most one record in flight in the assembly register and one in the output register.
- Latency: with the output register empty, data_out_valid rises on the 2nd clock edge after the final-beat handshake edge.
- seq_num is updated on acceptance of beat 0 of record 0.
- Sequence rule: expected sequence = 0 after reset and increments mod 256 per group. On mismatch:
  - pulse seq_err;
  - expected := received+1;
  - the record is still delivered.
- Early tlast (tlast on any beat other than the final beat of record N-1):
  - pulse frame_err;
  - discard the partial record (not delivered);
  - records already delivered stand;
  - stay in ASM with counters cleared.
- Missing tlast (final beat of record N-1 with tlast=0):
  - deliver that record;
  - pulse frame_err;
  - go to FULL, then DROP instead of ASM, discarding until the next tlast.
- err_cnt increments by the number of pulses in a cycle (0..2) and saturates at 16'hFFFF.
- Reset values:
  - FSM=ASM; s_axis_h2c_tready=1 on the first cycle after reset deasserts (0 while reset is held);
  - data_out_valid=0, data_out=0, seq_num=0, seq_err=0, frame_err=0, err_cnt=0;
  - expected sequence=0, counters=0.
- Reset mid-record discards all partial and held data immediately.

Optional Feature:
- H2C_SEQ_CHECK_EN
  - Defined: sequence checking as above.
  - Undefined: seq_err tied 0, expected-sequence logic removed; seq_num still captured; err_cnt counts frame_err only.

Test Plan:
- DATA_WIDTH=1000 (B0=BN=2), 16 beats with tlast on beat 15, seq byte 0, data_out_ready=1 -> 8 records out in order, bit-exact; seq_err=frame_err=0; seq_num=0.
- Default params, 2 groups with seq 0 then 5 -> group 2 delivers 8 records; one seq_err pulse on its beat 0; err_cnt=1; next group with seq 6 -> no error.
- data_out_ready=0 while a full group is sent -> record 0 held in output, record 1 assembled; tready=0 from the handshake edge after record 1's final beat; no data lost when ready=1.
- tlast on beat 5 of record 2 (DATA_WIDTH=1000) -> records 0,1 delivered, record 2 dropped, frame_err pulse; next 16-beat group decodes fully.
- Missing tlast on beat 15, then 4 extra beats ending in tlast, then a clean group -> 8 + 8 records; 1 frame_err; extra beats discarded.
- Assert s_axis_h2c_areset during record 3 -> data_out_valid=0 and err_cnt=0 next cycle; the following group expects seq 0.

Source files
------------

// File: rtl/axis_data_unpackge.sv
// H2C unpacker: strips group framing from AXIS beats and rebuilds DATA_WIDTH-bit records.
// Define H2C_SEQ_CHECK_EN to enable group sequence checking (seq_err); otherwise seq_err is tied low.
module axis_data_unpackge #(
  parameter int DATA_WIDTH            = 16000,
  parameter int AXIS_DATA_WIDTH       = 512,
  parameter int NUM_PACKETS_PER_GROUP = 8
) (
  input  logic                         s_axis_h2c_aclk,
  input  logic                         s_axis_h2c_areset,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_h2c_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_h2c_tkeep,
  input  logic                         s_axis_h2c_tlast,
  input  logic                         s_axis_h2c_tvalid,
  output logic                         s_axis_h2c_tready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic [7:0]                   seq_num,
  output logic                         seq_err,
  output logic                         frame_err,
  output logic [15:0]                  err_cnt,
  output logic [2:0]                   rx_state
);
  localparam int AW = AXIS_DATA_WIDTH;
  localparam int B0 = (DATA_WIDTH + 8 + AW - 1) / AW;
  localparam int BN = (DATA_WIDTH + AW - 1) / AW;
  localparam int NB = (B0 > BN) ? B0 : BN;
  localparam int RW = (NUM_PACKETS_PER_GROUP > 1) ? $clog2(NUM_PACKETS_PER_GROUP) : 1;
  localparam logic [7:0]    B0_LAST  = 8'(B0 - 1);
  localparam logic [7:0]    BN_LAST  = 8'(BN - 1);
  localparam logic [RW-1:0] REC_LAST = RW'(NUM_PACKETS_PER_GROUP - 1);

  typedef enum logic [2:0] {
    ASM  = 3'b001,
    FULL = 3'b010,
    DROP = 3'b100
  } state_t;

  state_t           state;
  logic [7:0]       beat_cnt;
  logic [RW-1:0]    rec_cnt;
  logic [NB*AW-1:0] asm_q;
  logic             full_rec0;
  logic             drop_pend;
  logic             load_pend;
  logic             load_rec0;

  logic beat_acc;
  logic first_beat;
  logic last_beat;
  logic last_rec;
  logic early_last;

  assign beat_acc   = s_axis_h2c_tvalid && s_axis_h2c_tready;
  assign first_beat = (beat_cnt == 8'd0) && (rec_cnt == '0);
  assign last_beat  = beat_cnt == ((rec_cnt == '0) ? B0_LAST : BN_LAST);
  assign last_rec   = rec_cnt == REC_LAST;
  assign early_last = s_axis_h2c_tlast && !(last_beat && last_rec);

  // Gated by reset so the port reads 0 while reset is held and 1 as soon as it drops.
  assign s_axis_h2c_tready = !s_axis_h2c_areset && (state != FULL);
  assign rx_state          = state;

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (s_axis_h2c_areset) begin
      state          <= ASM;
      beat_cnt       <= 8'd0;
      rec_cnt        <= '0;
      asm_q          <= '0;
      full_rec0      <= 1'b0;
      drop_pend      <= 1'b0;
      load_pend      <= 1'b0;
      load_rec0      <= 1'b0;
      frame_err      <= 1'b0;
      seq_num        <= 8'd0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      load_pend <= 1'b0;

      // The transfer is one cycle behind the FULL decision; asm_q is read before
      // any beat accepted on the same edge overwrites it.
      if (load_pend) begin
        data_out       <= load_rec0 ? asm_q[8 +: DATA_WIDTH] : asm_q[DATA_WIDTH-1:0];
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end

      case (state)
        ASM: begin
          if (beat_acc) begin
            if (first_beat) begin
              seq_num <= s_axis_h2c_tdata[7:0];
            end
            if (early_last) begin
              frame_err <= 1'b1;
              beat_cnt  <= 8'd0;
              rec_cnt   <= '0;
            end else begin
              asm_q[int'(beat_cnt)*AW +: AW] <= s_axis_h2c_tdata;
              if (last_beat) begin
                beat_cnt  <= 8'd0;
                rec_cnt   <= last_rec ? '0 : rec_cnt + RW'(1);
                full_rec0 <= (rec_cnt == '0);
                drop_pend <= last_rec && !s_axis_h2c_tlast;
                frame_err <= last_rec && !s_axis_h2c_tlast;
                state     <= FULL;
              end else begin
                beat_cnt <= beat_cnt + 8'd1;
              end
            end
          end
        end
        FULL: begin
          if (!data_out_valid || data_out_ready) begin
            load_pend <= 1'b1;
            load_rec0 <= full_rec0;
            drop_pend <= 1'b0;
            state     <= drop_pend ? DROP : ASM;
          end
        end
        DROP: begin
          if (beat_acc && s_axis_h2c_tlast) begin
            beat_cnt <= 8'd0;
            rec_cnt  <= '0;
            state    <= ASM;
          end
        end
        default: state <= ASM;
      endcase
    end
  end

`ifdef H2C_SEQ_CHECK_EN
  logic [7:0] exp_seq;

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (s_axis_h2c_areset) begin
      exp_seq <= 8'd0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if ((state == ASM) && beat_acc && first_beat) begin
        seq_err <= (s_axis_h2c_tdata[7:0] != exp_seq);
        exp_seq <= s_axis_h2c_tdata[7:0] + 8'd1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_cnt} + 17'(seq_err) + 17'(frame_err);

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (s_axis_h2c_areset) begin
      err_cnt <= 16'd0;
    end else begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  // tkeep is meaningless (beats are always full) and pad bits past the record end are dropped.
  logic unused_bits;
  assign unused_bits = ^{s_axis_h2c_tkeep, asm_q};

endmodule

// File: tb/tb_axis_data_unpackge.sv
// Scoreboard bench for axis_data_unpackge with DATA_WIDTH=1000 (two beats per record, 16 per group).
module tb_axis_data_unpackge;
  localparam int DW = 1000;
  localparam int AW = 512;
  localparam int NP = 8;
`ifdef H2C_SEQ_CHECK_EN
  localparam int SEQ_EN = 1;
`else
  localparam int SEQ_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [AW-1:0] tdata;
  logic [AW/8-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [7:0]    seq_num;
  logic          seq_err;
  logic          frame_err;
  logic [15:0]   err_cnt;
  logic [2:0]    rx_state;

  int n_checks = 0;
  int n_fail = 0;
  int n_seq_pulse = 0;
  int n_frame_pulse = 0;
  int exp_seq_errs = 0;
  int exp_frame_errs = 0;
  int rec_id = 0;
  logic [DW-1:0] expq[$];

  axis_data_unpackge #(
    .DATA_WIDTH(DW),
    .AXIS_DATA_WIDTH(AW),
    .NUM_PACKETS_PER_GROUP(NP)
  ) dut (
    .s_axis_h2c_aclk(clk),
    .s_axis_h2c_areset(areset),
    .s_axis_h2c_tdata(tdata),
    .s_axis_h2c_tkeep(tkeep),
    .s_axis_h2c_tlast(tlast),
    .s_axis_h2c_tvalid(tvalid),
    .s_axis_h2c_tready(tready),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .seq_num(seq_num),
    .seq_err(seq_err),
    .frame_err(frame_err),
    .err_cnt(err_cnt),
    .rx_state(rx_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rec_val(input int id);
    logic [DW-1:0] r;
    logic [31:0] w;
    for (int i = 0; i < DW; i++) begin
      w = (32'(id) * 32'h9E3779B9) ^ (32'(i / 32) * 32'h01000193) ^ 32'h5A5A3C3C;
      r[i] = w[i % 32];
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard on every output handshake and counts error pulses.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (seq_err === 1'b1) n_seq_pulse++;
    if (frame_err === 1'b1) n_frame_pulse++;
    if (data_out_valid === 1'b1 && data_out_ready === 1'b1) begin
      n_checks++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got %h, expected no record", data_out[63:0]);
      end else begin
        e = expq.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL record_data: got %h, expected %h (low 64 bits)", data_out[63:0], e[63:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [AW-1:0] d, input logic l);
    int t;
    t = 0;
    tdata = d;
    tlast = l;
    tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (tready === 1'b1) break;
      t++;
      if (t > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_timeout: got tready=0 for %0d cycles, expected 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  // early: beat index carrying a premature tlast (-1 none); nbeats: beats to send.
  task automatic send_group(input logic [7:0] seq, input int early, input logic final_last, input int nbeats);
    logic [1023:0] fbuf;
    logic [DW-1:0] rv;
    int idx;
    for (int r = 0; r < NP; r++) begin
      rv = rec_val(rec_id);
      rec_id++;
      if (r == 0) fbuf = {16'hFFFF, rv, seq};
      else        fbuf = {24'hFFFFFF, rv};
      for (int b = 0; b < 2; b++) begin
        idx = r * 2 + b;
        if (idx >= nbeats) return;
        if (idx == early) begin
          send_beat(fbuf[b*AW +: AW], 1'b1);
          return;
        end
        if (b == 1) expq.push_back(rv);
        send_beat(fbuf[b*AW +: AW], (idx == 2*NP-1) ? final_last : 1'b0);
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (expq.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, expq.size(), 0);
  endtask

  task automatic check_errs(input string name);
    check({name, "_seq_pulses"}, n_seq_pulse, exp_seq_errs);
    check({name, "_frame_pulses"}, n_frame_pulse, exp_frame_errs);
    check({name, "_err_cnt"}, err_cnt, exp_seq_errs + exp_frame_errs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    tdata = '0;
    tkeep = '1;
    tlast = 1'b0;
    tvalid = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tready_in_reset", tready, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("rst_tready", tready, 1);
    check("rst_valid", data_out_valid, 0);
    check("rst_data_zero", (data_out == '0), 1);
    check("rst_seq_num", seq_num, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_state", rx_state, 3'b001);
    check("rst_pulses", {seq_err, frame_err}, 2'b00);
    @(posedge clk);
    #1;

    // Clean group, seq 0
    send_group(8'd0, -1, 1'b1, 16);
    drain("t1_drain");
    check("t1_seq_num", seq_num, 8'd0);
    check_errs("t1");

    // Sequence jump 0 -> 5, then in-order 6
    send_group(8'd5, -1, 1'b1, 16);
    drain("t2_drain");
    exp_seq_errs += SEQ_EN;
    check("t2_seq_num", seq_num, 8'd5);
    check_errs("t2");
    send_group(8'd6, -1, 1'b1, 16);
    drain("t2b_drain");
    check_errs("t2b");

    // Backpressure: record 0 held, record 1 parked in assembly
    data_out_ready = 1'b0;
    fork
      send_group(8'd7, -1, 1'b1, 16);
    join_none
    repeat (40) @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_valid_held", data_out_valid, 1);
    check("t3_tready_low", tready, 0);
    check("t3_state_full", rx_state, 3'b010);
    check("t3_held_data", (expq.size() > 1 && data_out === expq[0]), 1);
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    wait fork;
    drain("t3_drain");
    check("t3_seq_num", seq_num, 8'd7);
    check_errs("t3");

    // Early tlast on beat 5 (last beat of record 2)
    send_group(8'd8, 5, 1'b1, 16);
    exp_frame_errs++;
    send_group(8'd9, -1, 1'b1, 16);
    drain("t4_drain");
    check_errs("t4");

    // Missing tlast, 4 junk beats, clean group
    send_group(8'd10, -1, 1'b0, 16);
    exp_frame_errs++;
    for (int i = 0; i < 4; i++) send_beat({16{32'hDEAD0000 + 32'(i)}}, (i == 3));
    send_group(8'd11, -1, 1'b1, 16);
    drain("t5_drain");
    check("t5_seq_num", seq_num, 8'd11);
    check_errs("t5");

    // Reset during record 3
    send_group(8'd12, -1, 1'b1, 7);
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_valid_after_rst", data_out_valid, 0);
    check("t6_err_cnt_after_rst", err_cnt, 0);
    check("t6_state_after_rst", rx_state, 3'b001);
    check("t6_pending_records", expq.size(), 0);
    expq.delete();
    @(posedge clk);
    #1;
    areset = 1'b0;
    n_seq_pulse = 0;
    n_frame_pulse = 0;
    exp_seq_errs = 0;
    exp_frame_errs = 0;
    send_group(8'd0, -1, 1'b1, 16);
    drain("t6_drain");
    check("t6_seq_num", seq_num, 8'd0);
    check_errs("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
